// File: rtl/mem_wb_stage.sv
// ---------------------------------------------------------------------------------------------
// mem_wb_stage
//
// MEM->WB pipeline boundary and write-back select. MEM-stage results are captured when the
// SRAM controller reports ready. Every cycle that memory is busy inserts a write-back bubble.
// The stage drives the register-file write port from registered state only, so no input
// reaches an output through combinational logic. It also keeps saturating stall statistics
// for performance debug.
//
// Parameters
//   CNT_W         width of the saturating stall/retire/max-stall counters
//
// Ports
//   clk           system clock
//   rst           synchronous active-high reset
//   ready         SRAM controller ready (0 = access in flight)
//   MEM_R_EN      MEM-stage instruction is a load
//   WB_EN         MEM-stage instruction writes the register file
//   Dest          destination register index
//   ALU_res       ALU result / address forwarded by MEM stage
//   MEM_out       load data from MEM stage (valid when ready=1)
//   cnt_clr       synchronous clear of all statistics counters
//   WB_WB_EN      register-file write enable
//   WB_Dest       register-file write index
//   WB_Value      register-file write data (load data or ALU result)
//   mem_busy      high while the stall tracker is in its stall state
//   stall_cycles  total cycles sampled with ready=0 (saturating)
//   retired_wb    total cycles with WB_WB_EN=1 (saturating)
//   max_stall     longest contiguous stall observed (saturating)
// ---------------------------------------------------------------------------------------------

module mem_wb_stage #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ready,
    input  logic             MEM_R_EN,
    input  logic             WB_EN,
    input  logic [3:0]       Dest,
    input  logic [31:0]      ALU_res,
    input  logic [31:0]      MEM_out,
    input  logic             cnt_clr,
    output logic             WB_WB_EN,
    output logic [3:0]       WB_Dest,
    output logic [31:0]      WB_Value,
    output logic             mem_busy,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] retired_wb,
    output logic [CNT_W-1:0] max_stall
);

    localparam logic [CNT_W-1:0] CntMax = '1;
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    typedef enum logic [0:0] {
        StRun,
        StStall
    } state_e;

    // ---------------------------------------------------------------------------------------
    // Pipeline registers
    // ---------------------------------------------------------------------------------------
    logic        wb_en_q;
    logic        mem_r_en_q;
    logic [3:0]  dest_q;
    logic [31:0] alu_q;
    logic [31:0] mem_q;

    // While memory is busy only the write enable is forced low; the payload holds so the
    // bubble carries no spurious data changes.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_en_q    <= 1'b0;
            mem_r_en_q <= 1'b0;
            dest_q     <= 4'h0;
            alu_q      <= 32'h0;
            mem_q      <= 32'h0;
        end else if (ready) begin
            wb_en_q    <= WB_EN;
            mem_r_en_q <= MEM_R_EN;
            dest_q     <= Dest;
            alu_q      <= ALU_res;
            mem_q      <= MEM_out;
        end else begin
            wb_en_q    <= 1'b0;
        end
    end

    always_comb begin
        WB_WB_EN = wb_en_q;
        WB_Dest  = dest_q;
        WB_Value = mem_r_en_q ? mem_q : alu_q;
    end

    // ---------------------------------------------------------------------------------------
    // Stall tracker FSM and statistics
    // ---------------------------------------------------------------------------------------
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cur_len_q, cur_len_d;
    logic [CNT_W-1:0] max_q, max_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    always_comb begin
        state_d   = state_q;
        cur_len_d = cur_len_q;
        max_d     = max_q;
        stall_d   = stall_q;
        retired_d = retired_q;

        unique case (state_q)
            StRun: begin
                if (!ready) begin
                    state_d   = StStall;
                    cur_len_d = CntOne;
                end
            end
            StStall: begin
                if (!ready) begin
                    if (cur_len_q != CntMax) begin
                        cur_len_d = cur_len_q + CntOne;
                    end
                end else begin
                    state_d   = StRun;
                    cur_len_d = '0;
                    if (cur_len_q > max_q) begin
                        max_d = cur_len_q;
                    end
                end
            end
            default: begin
                state_d   = StRun;
                cur_len_d = '0;
            end
        endcase

        if (!ready && (stall_q != CntMax)) begin
            stall_d = stall_q + CntOne;
        end
        if (wb_en_q && (retired_q != CntMax)) begin
            retired_d = retired_q + CntOne;
        end

        // Clear beats any same-cycle increment. Clearing cur_len mid-stall means only the
        // post-clear part of that stall can reach max_stall. FSM state is left alone.
        if (cnt_clr) begin
            cur_len_d = '0;
            max_d     = '0;
            stall_d   = '0;
            retired_d = '0;
        end
    end

    // Reset mid-stall drops cur_len without recording it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StRun;
            cur_len_q <= '0;
            max_q     <= '0;
            stall_q   <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            cur_len_q <= cur_len_d;
            max_q     <= max_d;
            stall_q   <= stall_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        mem_busy     = (state_q == StStall);
        stall_cycles = stall_q;
        retired_wb   = retired_q;
        max_stall    = max_q;
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        ready;
    logic        MEM_R_EN;
    logic        WB_EN;
    logic [3:0]  Dest;
    logic [31:0] ALU_res;
    logic [31:0] MEM_out;
    logic        cnt_clr;

    logic        WB_WB_EN;
    logic [3:0]  WB_Dest;
    logic [31:0] WB_Value;
    logic        mem_busy;
    logic [15:0] stall_cycles;
    logic [15:0] retired_wb;
    logic [15:0] max_stall;

    logic        n_WB_WB_EN;
    logic [3:0]  n_WB_Dest;
    logic [31:0] n_WB_Value;
    logic        n_mem_busy;
    logic [3:0]  n_stall_cycles;
    logic [3:0]  n_retired_wb;
    logic [3:0]  n_max_stall;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mem_wb_stage #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .ready(ready), .MEM_R_EN(MEM_R_EN), .WB_EN(WB_EN),
        .Dest(Dest), .ALU_res(ALU_res), .MEM_out(MEM_out), .cnt_clr(cnt_clr),
        .WB_WB_EN(WB_WB_EN), .WB_Dest(WB_Dest), .WB_Value(WB_Value), .mem_busy(mem_busy),
        .stall_cycles(stall_cycles), .retired_wb(retired_wb), .max_stall(max_stall)
    );

    // Narrow-counter instance shares all inputs; used for saturation checks.
    mem_wb_stage #(.CNT_W(4)) dut_n (
        .clk(clk), .rst(rst), .ready(ready), .MEM_R_EN(MEM_R_EN), .WB_EN(WB_EN),
        .Dest(Dest), .ALU_res(ALU_res), .MEM_out(MEM_out), .cnt_clr(cnt_clr),
        .WB_WB_EN(n_WB_WB_EN), .WB_Dest(n_WB_Dest), .WB_Value(n_WB_Value),
        .mem_busy(n_mem_busy), .stall_cycles(n_stall_cycles), .retired_wb(n_retired_wb),
        .max_stall(n_max_stall)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock edge; outputs are sampled 1 ns after it.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; ready = 1'b0; MEM_R_EN = 1'b0; WB_EN = 1'b0; Dest = 4'h0;
        ALU_res = 32'h0; MEM_out = 32'h0; cnt_clr = 1'b0;
        #1;

        // 1: reset with random inputs
        for (int i = 0; i < 2; i++) begin
            ready    = 1'($urandom);
            MEM_R_EN = 1'($urandom);
            WB_EN    = 1'b1;
            Dest     = 4'($urandom);
            ALU_res  = $urandom;
            MEM_out  = $urandom;
            step(1);
        end
        check("rst_wb_en", {31'h0, WB_WB_EN}, 32'h0);
        check("rst_dest", {28'h0, WB_Dest}, 32'h0);
        check("rst_value", WB_Value, 32'h0);
        check("rst_busy", {31'h0, mem_busy}, 32'h0);
        check("rst_stall", {16'h0, stall_cycles}, 32'h0);
        check("rst_retired", {16'h0, retired_wb}, 32'h0);
        check("rst_max", {16'h0, max_stall}, 32'h0);
        rst = 1'b0;

        // 2: ALU op
        ready = 1'b1; WB_EN = 1'b1; MEM_R_EN = 1'b0; Dest = 4'h3;
        ALU_res = 32'h0000_1234; MEM_out = 32'h5555_AAAA;
        step(1);
        check("alu_wb_en", {31'h0, WB_WB_EN}, 32'h1);
        check("alu_dest", {28'h0, WB_Dest}, 32'h3);
        check("alu_value", WB_Value, 32'h0000_1234);
        check("alu_retired0", {16'h0, retired_wb}, 32'h0);
        WB_EN = 1'b0;
        step(1);
        check("alu_retired1", {16'h0, retired_wb}, 32'h1);
        check("alu_bubble_en", {31'h0, WB_WB_EN}, 32'h0);

        // 3: load after a 3-cycle stall
        ready = 1'b0; WB_EN = 1'b1; MEM_R_EN = 1'b1; Dest = 4'h5;
        ALU_res = 32'h0000_0040; MEM_out = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            step(1);
            check("ld_stall_en", {31'h0, WB_WB_EN}, 32'h0);
            check("ld_stall_busy", {31'h0, mem_busy}, 32'h1);
            check("ld_stall_hold", {28'h0, WB_Dest}, 32'h3);
        end
        ready = 1'b1;
        step(1);
        check("ld_busy_off", {31'h0, mem_busy}, 32'h0);
        check("ld_wb_en", {31'h0, WB_WB_EN}, 32'h1);
        check("ld_dest", {28'h0, WB_Dest}, 32'h5);
        check("ld_value", WB_Value, 32'hDEAD_BEEF);
        check("ld_stall_cnt", {16'h0, stall_cycles}, 32'd3);
        check("ld_max", {16'h0, max_stall}, 32'd3);
        check("ld_retired", {16'h0, retired_wb}, 32'd1);

        // 4: stalls of 5 then 2; last capture has WB_EN=0
        WB_EN = 1'b0; MEM_R_EN = 1'b0;
        do_reset();
        ready = 1'b0; step(5);
        ready = 1'b1; step(1);
        ready = 1'b0; step(2);
        ready = 1'b1; Dest = 4'h9; ALU_res = 32'd77; step(1);
        check("two_max", {16'h0, max_stall}, 32'd5);
        check("two_stall", {16'h0, stall_cycles}, 32'd7);
        check("nowb_en", {31'h0, WB_WB_EN}, 32'h0);
        check("nowb_dest", {28'h0, WB_Dest}, 32'h9);
        check("nowb_value", WB_Value, 32'd77);

        // 5: saturation and clear
        do_reset();
        ready = 1'b0; step(20);
        check("sat_stall16", {16'h0, stall_cycles}, 32'd20);
        check("sat_stall4", {28'h0, n_stall_cycles}, 32'd15);
        ready = 1'b1; step(1);
        check("sat_max16", {16'h0, max_stall}, 32'd20);
        check("sat_max4", {28'h0, n_max_stall}, 32'd15);
        ready = 1'b0; cnt_clr = 1'b1; step(1);
        check("clr_stall16", {16'h0, stall_cycles}, 32'd0);
        check("clr_stall4", {28'h0, n_stall_cycles}, 32'd0);
        check("clr_max", {16'h0, max_stall}, 32'd0);
        check("clr_busy", {31'h0, mem_busy}, 32'h1);
        cnt_clr = 1'b0; step(1);
        ready = 1'b1; step(1);
        check("clr_post_max", {16'h0, max_stall}, 32'd1);
        check("clr_post_stall", {16'h0, stall_cycles}, 32'd1);
        WB_EN = 1'b1; step(18);
        check("ret_sat16", {16'h0, retired_wb}, 32'd17);
        check("ret_sat4", {28'h0, n_retired_wb}, 32'd15);

        // 6: reset on cycle 2 of a stall
        do_reset();
        WB_EN = 1'b1; Dest = 4'h7; ALU_res = 32'hCAFE_0001; ready = 1'b1; step(1);
        check("mid_pre_en", {31'h0, WB_WB_EN}, 32'h1);
        ready = 1'b0; step(1);
        check("mid_busy", {31'h0, mem_busy}, 32'h1);
        rst = 1'b1; step(1);
        rst = 1'b0;
        check("mid_busy_off", {31'h0, mem_busy}, 32'h0);
        check("mid_en", {31'h0, WB_WB_EN}, 32'h0);
        check("mid_dest", {28'h0, WB_Dest}, 32'h0);
        check("mid_value", WB_Value, 32'h0);
        WB_EN = 1'b0; ready = 1'b1; step(1);
        check("mid_max", {16'h0, max_stall}, 32'd0);
        check("mid_stall", {16'h0, stall_cycles}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errors);
        $finish;
    end

endmodule
